// File: rtl/fpu_cmp_seq.sv
// fpu_cmp_seq: sequenced floating-point sign-inject / min-max / compare /
// classify unit with a fixed, parameterised latency.
//
// Ports
//   clk          single clock, rising edge
//   resetn       synchronous, active-high reset (1 = held in reset)
//   in_valid     request present; accepted when in_ready is high
//   in_ready     idle and not in reset
//   op           0 FSGNJ 1 FSGNJN 2 FSGNJX 3 FMIN 4 FMAX 5 FEQ 6 FLT 7 FLE 8 FCLASS
//   rs1, rs2     IEEE-754 operands (FLEN bits)
//   out_valid    result/fflags_out valid, held until out_ready
//   out_ready    consumer takes the result
//   result       operation result
//   fflags_out   {NV,DZ,OF,UF,NX} for the completed op
//   fflags_acc   sticky OR of fflags_out over completed ops
//   fflags_clr   clears fflags_acc
//   busy         operation in flight or awaiting handshake
//
// state  | meaning
// -------+---------------------------------------------------
// S_IDLE | waiting for a request, in_ready high
// S_EXEC | operands captured, latency down-counter running
// S_DONE | result registered, out_valid high until out_ready
module fpu_cmp_seq #(
  parameter int FLEN = 32,
  parameter int LAT  = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [FLEN-1:0] rs1,
  input  logic [FLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] result,
  output logic [4:0]      fflags_out,
  output logic [4:0]      fflags_acc,
  input  logic            fflags_clr,
  output logic            busy
);

  localparam int EW = (FLEN == 64) ? 11 : 8;
  localparam int MW = FLEN - 1 - EW;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
  localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [3:0]      op_q;
  logic [FLEN-1:0] a_q, b_q;
  logic            accept, handshake, exec_last;

  logic [FLEN-1:0] res_c;
  logic [4:0]      flg_c;

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  assign exec_last = (state == S_EXEC) && (cnt == '0);

  // state register
  always_ff @(posedge clk) begin
    if (resetn) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept)    state_nx = S_EXEC;
      S_EXEC:  if (exec_last) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE) && !resetn;
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
  end

  // operand capture, latency counter, result and flag registers
  always_ff @(posedge clk) begin
    if (resetn) begin
      cnt        <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result     <= '0;
      fflags_out <= '0;
      fflags_acc <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= rs1;
        b_q  <= rs2;
        cnt  <= CNT_LOAD;
      end else if ((state == S_EXEC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (exec_last) begin
        result     <= res_c;
        fflags_out <= flg_c;
      end

      // clear and handshake together leave only the op being retired
      if (handshake)       fflags_acc <= fflags_clr ? fflags_out : (fflags_acc | fflags_out);
      else if (fflags_clr) fflags_acc <= '0;
    end
  end

  // operand decode
  logic            sa, sb;
  logic [EW-1:0]   ea, eb;
  logic [MW-1:0]   ma, mb;
  logic [FLEN-2:0] mag_a, mag_b;
  logic            a_emax, b_emax, a_ezero, b_ezero, a_mzero, b_mzero;
  logic            a_nan, b_nan, a_snan, b_snan, any_nan, any_snan, both_zero;
  logic            ord_lt, flt_raw, feq_raw;
  logic [9:0]      cls;

  always_comb begin
    sa        = a_q[FLEN-1];
    sb        = b_q[FLEN-1];
    ea        = a_q[FLEN-2:MW];
    eb        = b_q[FLEN-2:MW];
    ma        = a_q[MW-1:0];
    mb        = b_q[MW-1:0];
    mag_a     = a_q[FLEN-2:0];
    mag_b     = b_q[FLEN-2:0];
    a_emax    = &ea;
    b_emax    = &eb;
    a_ezero   = ~|ea;
    b_ezero   = ~|eb;
    a_mzero   = ~|ma;
    b_mzero   = ~|mb;
    a_nan     = a_emax & ~a_mzero;
    b_nan     = b_emax & ~b_mzero;
    a_snan    = a_nan & ~ma[MW-1];
    b_snan    = b_nan & ~mb[MW-1];
    any_nan   = a_nan | b_nan;
    any_snan  = a_snan | b_snan;
    both_zero = (mag_a == '0) && (mag_b == '0);

    // total order on non-NaN values with -0 below +0 (used by FMIN/FMAX);
    // FLT masks out the signed-zero case so that +0 == -0 there
    if (sa != sb) ord_lt = sa;
    else          ord_lt = sa ? (mag_a > mag_b) : (mag_a < mag_b);
    flt_raw = ord_lt & ~both_zero;
    feq_raw = (a_q == b_q) | both_zero;

    cls    = '0;
    cls[0] = sa  & a_emax  & a_mzero;
    cls[1] = sa  & ~a_emax & ~a_ezero;
    cls[2] = sa  & a_ezero & ~a_mzero;
    cls[3] = sa  & a_ezero & a_mzero;
    cls[4] = ~sa & a_ezero & a_mzero;
    cls[5] = ~sa & a_ezero & ~a_mzero;
    cls[6] = ~sa & ~a_emax & ~a_ezero;
    cls[7] = ~sa & a_emax  & a_mzero;
    cls[8] = a_snan;
    cls[9] = a_nan & ~a_snan;
  end

  // operation select
  always_comb begin
    res_c = '0;
    flg_c = '0;
    case (op_q)
      4'd0: res_c = {sb, mag_a};
      4'd1: res_c = {~sb, mag_a};
      4'd2: res_c = {sa ^ sb, mag_a};
      4'd3, 4'd4: begin
        if (a_nan && b_nan)  res_c = CANON_NAN;
        else if (a_nan)      res_c = b_q;
        else if (b_nan)      res_c = a_q;
        else if (op_q == 4'd3) res_c = ord_lt ? a_q : b_q;
        else                   res_c = ord_lt ? b_q : a_q;
        flg_c[4] = any_snan;
      end
      4'd5: begin
        res_c    = {{(FLEN-1){1'b0}}, feq_raw & ~any_nan};
        flg_c[4] = any_snan;
      end
      4'd6: begin
        res_c    = {{(FLEN-1){1'b0}}, flt_raw & ~any_nan};
        flg_c[4] = any_nan;
      end
      4'd7: begin
        res_c    = {{(FLEN-1){1'b0}}, (flt_raw | feq_raw) & ~any_nan};
        flg_c[4] = any_nan;
      end
      4'd8: res_c = {{(FLEN-10){1'b0}}, cls};
      default: flg_c[4] = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fpu_cmp_seq.sv
// Testbench for fpu_cmp_seq (FLEN=32, LAT=3): directed spec vectors followed by
// randomized operations checked against a value-level reference model.
module tb_fpu_cmp_seq;

  localparam int FLEN = 32;
  localparam int LAT  = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [FLEN-1:0] rs1, rs2;
  logic            out_valid;
  logic            out_ready;
  logic [FLEN-1:0] result;
  logic [4:0]      fflags_out, fflags_acc;
  logic            fflags_clr;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_acc = '0;

  fpu_cmp_seq #(.FLEN(FLEN), .LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .fflags_out(fflags_out), .fflags_acc(fflags_acc),
    .fflags_clr(fflags_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // value class: 0 -inf 1 -norm 2 -sub 3 -0 4 +0 5 +sub 6 +norm 7 +inf 8 sNaN 9 qNaN
  function automatic int fclass(input logic [31:0] x);
    int e, m;
    bit s;
    s = x[31];
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    if (e == 255) begin
      if (m == 0) return s ? 0 : 7;
      return (m >= 32'h400000) ? 9 : 8;
    end
    if (e == 0) begin
      if (m == 0) return s ? 3 : 4;
      return s ? 2 : 5;
    end
    return s ? 1 : 6;
  endfunction

  // signed ordering key: larger key = larger value; +0 and -0 share key 0
  function automatic longint fkey(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  // returns {flags[4:0], result[31:0]}
  function automatic logic [36:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int ca, cb;
    bit an, bn, sn;
    longint ka, kb;
    logic [31:0] r, one;
    logic [4:0] f;
    ca = fclass(a); cb = fclass(b);
    an = (ca >= 8); bn = (cb >= 8);
    sn = (ca == 8) || (cb == 8);
    ka = fkey(a); kb = fkey(b);
    r = 32'h0; f = 5'h0; one = 32'h1;
    case (o)
      4'd0: r = {b[31], a[30:0]};
      4'd1: r = {~b[31], a[30:0]};
      4'd2: r = {a[31] ^ b[31], a[30:0]};
      4'd3, 4'd4: begin
        if (an && bn)    r = 32'h7FC00000;
        else if (an)     r = b;
        else if (bn)     r = a;
        else if (o == 4'd3) r = ((ka < kb) || (ka == kb && a[31])) ? a : b;
        else                r = ((ka > kb) || (ka == kb && !a[31])) ? a : b;
        if (sn) f = 5'b10000;
      end
      4'd5: begin
        r = (!an && !bn && ka == kb) ? one : 32'h0;
        if (sn) f = 5'b10000;
      end
      4'd6: begin
        if (an || bn) f = 5'b10000; else r = (ka < kb) ? one : 32'h0;
      end
      4'd7: begin
        if (an || bn) f = 5'b10000; else r = (ka <= kb) ? one : 32'h0;
      end
      4'd8: r = one << ca;
      default: f = 5'b10000;
    endcase
    return {f, r};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      3: x = 32'h00000000;
      4: x = 32'h80000000;
      5: x = {x[31], 8'hFF, 23'h0};
      6: x = {x[31], 8'hFF, 1'b1, x[21:0]};
      7: x = {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
      8: x = {x[31], 8'h00, x[22:0]};
      9: x = {x[31], 8'h7F, x[22:0]};
      default: ;
    endcase
    return x;
  endfunction

  // One complete operation: accept, latency, hold, handshake, acc update.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit clr_hs);
    logic [36:0] exp;
    exp = model(o, a, b);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    step();                                   // accept edge
    for (int i = 0; i < LAT; i++) begin
      in_valid = 1'($urandom); op = 4'($urandom); rs1 = $urandom; rs2 = $urandom;
      chk({tag, ".early_valid"}, out_valid, 0);
      chk({tag, ".busy"}, busy, 1);
      step();
    end
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".result"}, result, exp[31:0]);
    chk({tag, ".fflags_out"}, fflags_out, exp[36:32]);
    chk({tag, ".in_ready_busy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      step();
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_result"}, result, exp[31:0]);
      chk({tag, ".hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1; fflags_clr = clr_hs;
    step();                                   // handshake edge
    in_valid = 1'b0; out_ready = 1'b0; fflags_clr = 1'b0;
    exp_acc = clr_hs ? exp[36:32] : (exp_acc | exp[36:32]);
    chk({tag, ".valid_drop"}, out_valid, 0);
    chk({tag, ".in_ready_back"}, in_ready, 1);
    chk({tag, ".fflags_acc"}, fflags_acc, exp_acc);
  endtask

  initial begin
    logic [31:0] ra, rb;
    resetn = 1'b1; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    out_ready = 1'b0; fflags_clr = 1'b0;

    // reset state
    step(); step();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.result", result, 0);
    chk("rst.fflags_out", fflags_out, 0);
    chk("rst.fflags_acc", fflags_acc, 0);
    resetn = 1'b0;
    step();
    chk("rst.release_ready", in_ready, 1);

    // directed vectors
    run_op("fmin_basic", 4'd3, 32'h3F800000, 32'hC0000000, 0, 1'b0);
    chk("fmin_basic.value", result, 32'hC0000000);
    run_op("feq_snan", 4'd5, 32'h7F800001, 32'h3F800000, 0, 1'b0);
    chk("feq_snan.acc_nv", fflags_acc, 5'b10000);
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    exp_acc = '0;
    chk("clr_alone.acc", fflags_acc, 0);
    run_op("fmax_zeros", 4'd4, 32'h00000000, 32'h80000000, 0, 1'b0);
    chk("fmax_zeros.value", result, 32'h00000000);
    run_op("fmin_zeros", 4'd3, 32'h00000000, 32'h80000000, 0, 1'b0);
    chk("fmin_zeros.value", result, 32'h80000000);
    run_op("fmin_qnans", 4'd3, 32'h7FC00000, 32'h7FC00000, 0, 1'b0);
    chk("fmin_qnans.value", result, 32'h7FC00000);
    run_op("fclass_negz", 4'd8, 32'h80000000, 32'h0, 0, 1'b0);
    chk("fclass_negz.value", result, 32'h00000008);
    run_op("fclass_snan", 4'd8, 32'h7F800001, 32'h0, 0, 1'b0);
    chk("fclass_snan.value", result, 32'h00000100);
    run_op("illegal", 4'd12, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0);
    chk("illegal.flags", fflags_out, 5'b10000);
    run_op("flt_qnan", 4'd6, 32'h7FC00000, 32'h3F800000, 0, 1'b0);
    run_op("fle_zeros", 4'd7, 32'h80000000, 32'h00000000, 0, 1'b0);
    run_op("hold5", 4'd4, 32'h40400000, 32'hBF800000, 5, 1'b0);
    run_op("clr_with_hs", 4'd0, 32'h3F800000, 32'h80000000, 1, 1'b1);
    chk("clr_with_hs.acc", fflags_acc, 0);

    // reset one cycle after accept aborts the op
    in_valid = 1'b1; op = 4'd5; rs1 = 32'h7F800001; rs2 = 32'h0;
    step();
    in_valid = 1'b0; resetn = 1'b1;
    step();
    exp_acc = '0;
    chk("abort.busy", busy, 0);
    chk("abort.in_ready_in_rst", in_ready, 0);
    chk("abort.result", result, 0);
    resetn = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("abort.no_valid", out_valid, 0);
      chk("abort.acc", fflags_acc, 0);
      chk("abort.in_ready", in_ready, 1);
    end

    // randomized operations
    for (int n = 0; n < 200; n++) begin
      ra = gen_operand();
      rb = ($urandom_range(0, 4) == 0) ? ra : gen_operand();
      run_op("rand", 4'($urandom_range(0, 15)), ra, rb,
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
